// File: rtl/mnacidpro_sequencer.sv
// mnacidpro_sequencer
// Protocol sequencer for the magnetic-bead nucleic-acid processing chip.
// One start command runs LYSIS, wash_reps x WASH, ELUTE and COLLECT, with an
// all-closed SETTLE interval after each pumped step (none after COLLECT).
// Valve convention: 1 = pressurised = closed.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle pulse, accepted only in IDLE
//   abort             level, forces IDLE (beats start)
//   lysis_strokes     pump strokes for LYSIS
//   wash_strokes      pump strokes per WASH repetition
//   wash_reps         number of WASH repetitions
//   elute_strokes     pump strokes for ELUTE and for COLLECT
//   *_ctl             reagent / loop / bead / outlet valves
//   pump1..pump3      peristaltic pump valves
//   busy, done, step  status: not-IDLE, completion pulse, state code
module mnacidpro_sequencer #(
   parameter int unsigned PUMP_DIV   = 4,
   parameter int unsigned SETTLE_CYC = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] lysis_strokes,
   input  logic [CNT_W-1:0] wash_strokes,
   input  logic [3:0]       wash_reps,
   input  logic [CNT_W-1:0] elute_strokes,
   output logic             lysis_ctl,
   output logic             wash_ctl,
   output logic             elute_ctl,
   output logic             horiz_ctl,
   output logic             vertical_ctl,
   output logic             loop_exit_ctl,
   output logic             bead_vtl_ctl,
   output logic             bead_trap_ctl,
   output logic             collection_ctl,
   output logic             pump1,
   output logic             pump2,
   output logic             pump3,
   output logic             busy,
   output logic             done,
   output logic [2:0]       step
);

   localparam int unsigned DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
   localparam int unsigned SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PUMP_DIV - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
   localparam logic [2:0]       PH_LAST  = 3'd5;

   // Valve vector order: lysis, wash, elute, horiz, vertical, loop_exit,
   // bead_vtl, bead_trap, collection. A 0 bit is an open valve.
   localparam logic [8:0] CTL_CLOSED  = 9'b111111111;
   localparam logic [8:0] CTL_LYSIS   = 9'b011001101;
   localparam logic [8:0] CTL_WASH    = 9'b101110011;
   localparam logic [8:0] CTL_ELUTE   = 9'b110001111;
   localparam logic [8:0] CTL_COLLECT = 9'b111110010;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LYSIS   = 3'd1,
      S_WASH    = 3'd2,
      S_ELUTE   = 3'd3,
      S_COLLECT = 3'd4,
      S_SETTLE  = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t           state, state_nx;
   state_t           ret, ret_nx;          // step entered when SETTLE ends
   logic [2:0]       phase, phase_nx;
   logic [DIV_W-1:0] div_cnt, div_nx;
   logic [CNT_W-1:0] stroke, stroke_nx;
   logic [3:0]       rep, rep_nx;          // WASH repetitions completed
   logic [SET_W-1:0] settle_cnt, settle_nx;
   logic [CNT_W-1:0] lat_lysis, lat_lysis_nx;
   logic [CNT_W-1:0] lat_wash, lat_wash_nx;
   logic [3:0]       lat_reps, lat_reps_nx;
   logic [CNT_W-1:0] lat_elute, lat_elute_nx;

   logic [CNT_W-1:0] target;
   logic             pumped;
   logic             stroke_end;
   logic             wash_ok;
   logic             elute_ok;

   logic [8:0]       ctl_d, ctl_q;
   logic [2:0]       pump_d, pump_q;
   logic             busy_d, done_d;
   logic [2:0]       step_d;

   // Six-phase peristaltic pattern {pump1,pump2,pump3}
   function automatic logic [2:0] pump_pat(input logic [2:0] ph);
      logic [2:0] p;
      p = 3'b111;
      case (ph)
         3'd0: p = 3'b011;
         3'd1: p = 3'b001;
         3'd2: p = 3'b101;
         3'd3: p = 3'b100;
         3'd4: p = 3'b110;
         3'd5: p = 3'b010;
         default: p = 3'b111;
      endcase
      return p;
   endfunction

   // State and counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         ret        <= S_IDLE;
         phase      <= '0;
         div_cnt    <= '0;
         stroke     <= '0;
         rep        <= '0;
         settle_cnt <= '0;
         lat_lysis  <= '0;
         lat_wash   <= '0;
         lat_reps   <= '0;
         lat_elute  <= '0;
         ctl_q      <= CTL_CLOSED;
         pump_q     <= 3'b111;
         busy       <= 1'b0;
         done       <= 1'b0;
         step       <= 3'd0;
      end else begin
         state      <= state_nx;
         ret        <= ret_nx;
         phase      <= phase_nx;
         div_cnt    <= div_nx;
         stroke     <= stroke_nx;
         rep        <= rep_nx;
         settle_cnt <= settle_nx;
         lat_lysis  <= lat_lysis_nx;
         lat_wash   <= lat_wash_nx;
         lat_reps   <= lat_reps_nx;
         lat_elute  <= lat_elute_nx;
         ctl_q      <= ctl_d;
         pump_q     <= pump_d;
         busy       <= busy_d;
         done       <= done_d;
         step       <= step_d;
      end
   end

   // Next state, counters and the registered output decode of the next state
   always_comb begin
      state_nx     = state;
      ret_nx       = ret;
      phase_nx     = phase;
      div_nx       = div_cnt;
      stroke_nx    = stroke;
      rep_nx       = rep;
      settle_nx    = settle_cnt;
      lat_lysis_nx = lat_lysis;
      lat_wash_nx  = lat_wash;
      lat_reps_nx  = lat_reps;
      lat_elute_nx = lat_elute;
      target       = '0;
      pumped       = 1'b0;
      ctl_d        = CTL_CLOSED;
      pump_d       = 3'b111;

      wash_ok  = (lat_wash != '0) && (lat_reps != 4'd0);
      elute_ok = (lat_elute != '0);

      case (state)
         S_LYSIS:   begin target = lat_lysis; pumped = 1'b1; end
         S_WASH:    begin target = lat_wash;  pumped = 1'b1; end
         S_ELUTE:   begin target = lat_elute; pumped = 1'b1; end
         S_COLLECT: begin target = lat_elute; pumped = 1'b1; end
         default:   begin target = '0;        pumped = 1'b0; end
      endcase

      // Last clock of the final stroke of a pumped step
      stroke_end = pumped && (div_cnt == DIV_LAST) && (phase == PH_LAST) &&
                   (stroke == target - CNT_W'(1));

      case (state)
         S_IDLE: begin
            if (start) begin
               lat_lysis_nx = lysis_strokes;
               lat_wash_nx  = wash_strokes;
               lat_reps_nx  = wash_reps;
               lat_elute_nx = elute_strokes;
               rep_nx       = 4'd0;
               // Zero-count steps are skipped, so pick the first real one
               if (lysis_strokes != '0)
                  state_nx = S_LYSIS;
               else if ((wash_strokes != '0) && (wash_reps != 4'd0))
                  state_nx = S_WASH;
               else if (elute_strokes != '0)
                  state_nx = S_ELUTE;
               else
                  state_nx = S_DONE;
            end
         end

         S_LYSIS, S_WASH, S_ELUTE, S_COLLECT: begin
            if (div_cnt == DIV_LAST) begin
               div_nx = '0;
               if (phase == PH_LAST) begin
                  phase_nx  = 3'd0;
                  stroke_nx = stroke + CNT_W'(1);
               end else begin
                  phase_nx = phase + 3'd1;
               end
            end else begin
               div_nx = div_cnt + DIV_W'(1);
            end

            if (stroke_end) begin
               phase_nx  = 3'd0;
               div_nx    = '0;
               stroke_nx = '0;
               settle_nx = '0;
               state_nx  = S_SETTLE;
               case (state)
                  S_LYSIS: begin
                     if (wash_ok)       ret_nx = S_WASH;
                     else if (elute_ok) ret_nx = S_ELUTE;
                     else               ret_nx = S_DONE;
                  end
                  S_WASH: begin
                     rep_nx = rep + 4'd1;
                     if (rep_nx < lat_reps) ret_nx = S_WASH;
                     else if (elute_ok)     ret_nx = S_ELUTE;
                     else                   ret_nx = S_DONE;
                  end
                  S_ELUTE: ret_nx = S_COLLECT;
                  default: state_nx = S_DONE;   // COLLECT has no SETTLE
               endcase
            end
         end

         S_SETTLE: begin
            if (settle_cnt == SET_LAST) begin
               settle_nx = '0;
               state_nx  = ret;
            end else begin
               settle_nx = settle_cnt + SET_W'(1);
            end
         end

         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase

      // abort overrides everything, including a same-cycle start
      if (abort) begin
         state_nx  = S_IDLE;
         ret_nx    = S_IDLE;
         phase_nx  = 3'd0;
         div_nx    = '0;
         stroke_nx = '0;
         rep_nx    = 4'd0;
         settle_nx = '0;
      end

      // Output decode of the next state so outputs leave a flop directly
      case (state_nx)
         S_LYSIS:   begin ctl_d = CTL_LYSIS;   pump_d = pump_pat(phase_nx); end
         S_WASH:    begin ctl_d = CTL_WASH;    pump_d = pump_pat(phase_nx); end
         S_ELUTE:   begin ctl_d = CTL_ELUTE;   pump_d = pump_pat(phase_nx); end
         S_COLLECT: begin ctl_d = CTL_COLLECT; pump_d = pump_pat(phase_nx); end
         default:   begin ctl_d = CTL_CLOSED;  pump_d = 3'b111;             end
      endcase
   end

   assign busy_d = (state_nx != S_IDLE);
   assign done_d = (state_nx == S_DONE);
   assign step_d = state_nx;

   assign lysis_ctl      = ctl_q[8];
   assign wash_ctl       = ctl_q[7];
   assign elute_ctl      = ctl_q[6];
   assign horiz_ctl      = ctl_q[5];
   assign vertical_ctl   = ctl_q[4];
   assign loop_exit_ctl  = ctl_q[3];
   assign bead_vtl_ctl   = ctl_q[2];
   assign bead_trap_ctl  = ctl_q[1];
   assign collection_ctl = ctl_q[0];
   assign pump1          = pump_q[2];
   assign pump2          = pump_q[1];
   assign pump3          = pump_q[0];

endmodule

// File: tb/tb_mnacidpro_sequencer.sv
// tb_mnacidpro_sequencer
// Self-checking bench: a timeline model (list of step code + offset per
// cycle, built from the stroke/settle arithmetic) is compared against every
// output on every cycle of directed and randomized runs.
module tb_mnacidpro_sequencer;

   localparam int unsigned PD = 2;
   localparam int unsigned SC = 3;
   localparam int unsigned CW = 8;

   logic          clk = 1'b0;
   logic          rst, start, abort;
   logic [CW-1:0] lysis_strokes, wash_strokes, elute_strokes;
   logic [3:0]    wash_reps;
   logic lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl, loop_exit_ctl;
   logic bead_vtl_ctl, bead_trap_ctl, collection_ctl, pump1, pump2, pump3;
   logic busy, done;
   logic [2:0] step;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   int          q_code[$];
   int          q_off[$];

   mnacidpro_sequencer #(.PUMP_DIV(PD), .SETTLE_CYC(SC), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .lysis_strokes(lysis_strokes), .wash_strokes(wash_strokes),
      .wash_reps(wash_reps), .elute_strokes(elute_strokes),
      .lysis_ctl(lysis_ctl), .wash_ctl(wash_ctl), .elute_ctl(elute_ctl),
      .horiz_ctl(horiz_ctl), .vertical_ctl(vertical_ctl),
      .loop_exit_ctl(loop_exit_ctl), .bead_vtl_ctl(bead_vtl_ctl),
      .bead_trap_ctl(bead_trap_ctl), .collection_ctl(collection_ctl),
      .pump1(pump1), .pump2(pump2), .pump3(pump3),
      .busy(busy), .done(done), .step(step)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Open-valve list per step; order lysis,wash,elute,horiz,vertical,
   // loop_exit,bead_vtl,bead_trap,collection
   function automatic logic [8:0] exp_ctl(input int code);
      logic [8:0] v;
      v = 9'h1FF;
      case (code)
         1: begin v[8] = 1'b0; v[5] = 1'b0; v[4] = 1'b0; v[1] = 1'b0; end
         2: begin v[7] = 1'b0; v[3] = 1'b0; v[2] = 1'b0; end
         3: begin v[6] = 1'b0; v[5] = 1'b0; v[4] = 1'b0; end
         4: begin v[3] = 1'b0; v[2] = 1'b0; v[0] = 1'b0; end
         default: v = 9'h1FF;
      endcase
      return v;
   endfunction

   function automatic logic [2:0] exp_pump(input int code, input int off);
      logic [2:0] tbl [6];
      tbl[0] = 3'b011; tbl[1] = 3'b001; tbl[2] = 3'b101;
      tbl[3] = 3'b100; tbl[4] = 3'b110; tbl[5] = 3'b010;
      if (code >= 1 && code <= 4) return tbl[(off / PD) % 6];
      return 3'b111;
   endfunction

   task automatic check_cycle(input int code, input int off, input string where);
      chk($sformatf("%s step", where), 32'(step), 32'(code));
      chk($sformatf("%s busy", where), 32'(busy), 32'(code != 0));
      chk($sformatf("%s done", where), 32'(done), 32'(code == 6));
      chk($sformatf("%s ctl", where),
          32'({lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
               loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl, collection_ctl}),
          32'(exp_ctl(code)));
      chk($sformatf("%s pump", where), 32'({pump1, pump2, pump3}),
          32'(exp_pump(code, off)));
   endtask

   task automatic push_seg(input int code, input int dur);
      for (int i = 0; i < dur; i++) begin
         q_code.push_back(code);
         q_off.push_back(i);
      end
   endtask

   task automatic drive_counts_random();
      lysis_strokes = CW'($urandom_range(0, 5));
      wash_strokes  = CW'($urandom_range(0, 5));
      wash_reps     = 4'($urandom_range(0, 5));
      elute_strokes = CW'($urandom_range(0, 5));
   endtask

   // One protocol run starting in an IDLE cycle. kill_kind 1=abort 2=rst at
   // cycle kill_at; clash drives start+abort together in IDLE; hold keeps
   // start high for the whole busy period.
   task automatic run(input int l, input int w, input int r, input int e,
                      input int kill_at, input int kill_kind,
                      input bit clash, input bit hold);
      q_code.delete();
      q_off.delete();
      if (l > 0) begin push_seg(1, l * 6 * PD); push_seg(5, SC); end
      if (w > 0 && r > 0)
         for (int k = 0; k < r; k++) begin push_seg(2, w * 6 * PD); push_seg(5, SC); end
      if (e > 0) begin
         push_seg(3, e * 6 * PD); push_seg(5, SC); push_seg(4, e * 6 * PD);
      end
      push_seg(6, 1);

      @(negedge clk);
      check_cycle(0, 0, "idle0");
      start         = 1'b1;
      lysis_strokes = CW'(l);
      wash_strokes  = CW'(w);
      wash_reps     = 4'(r);
      elute_strokes = CW'(e);
      if (clash) begin
         abort = 1'b1;
         @(negedge clk);
         check_cycle(0, 0, "clash1");
         abort = 1'b0;
         start = 1'b0;
         @(negedge clk);
         check_cycle(0, 0, "clash2");
         return;
      end
      for (int c = 1; c <= q_code.size(); c++) begin
         @(negedge clk);
         check_cycle(q_code[c-1], q_off[c-1], $sformatf("c%0d", c));
         start = hold ? 1'b1 : 1'($urandom_range(0, 3) == 0);
         drive_counts_random();
         if (c == kill_at) begin
            if (kill_kind == 2) rst = 1'b1;
            else                abort = 1'b1;
            @(negedge clk);
            check_cycle(0, 0, $sformatf("kill%0d", c + 1));
            rst   = 1'b0;
            abort = 1'b0;
            start = 1'b0;
            return;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      lysis_strokes = '0;
      wash_strokes  = '0;
      wash_reps     = '0;
      elute_strokes = '0;
      repeat (3) @(negedge clk);
      check_cycle(0, 0, "reset");
      rst = 1'b0;

      run(2, 1, 2, 1, -1, 0, 1'b0, 1'b0);   // full run, DONE at cycle 85
      run(0, 1, 0, 1, -1, 0, 1'b0, 1'b0);   // lysis and washes skipped
      run(2, 1, 2, 1, 30, 1, 1'b0, 1'b0);   // abort inside WASH
      run(2, 1, 2, 1, -1, 0, 1'b0, 1'b0);   // restart after abort
      run(2, 1, 2, 1, 80, 2, 1'b0, 1'b0);   // rst inside COLLECT
      run(1, 1, 1, 1, -1, 0, 1'b1, 1'b0);   // start+abort in IDLE
      run(1, 2, 1, 1, -1, 0, 1'b0, 1'b1);   // start held while busy
      run(0, 0, 3, 0, -1, 0, 1'b0, 1'b0);   // every step skipped
      run(3, 0, 2, 0, -1, 0, 1'b0, 1'b0);   // lysis only

      for (int n = 0; n < 25; n++) begin
         int l, w, r, e, kat, kk, len;
         l = $urandom_range(0, 3);
         w = $urandom_range(0, 2);
         r = $urandom_range(0, 3);
         e = $urandom_range(0, 2);
         len = ((l > 0) ? l * 6 * PD + SC : 0) +
               ((w > 0 && r > 0) ? r * (w * 6 * PD + SC) : 0) +
               ((e > 0) ? 2 * e * 6 * PD + SC : 0) + 1;
         kk  = 0;
         kat = -1;
         if ($urandom_range(0, 3) == 0) begin
            kk  = $urandom_range(1, 2);
            kat = $urandom_range(1, len);
         end
         run(l, w, r, e, kat, kk, 1'b0, 1'b0);
      end

      @(negedge clk);
      check_cycle(0, 0, "final");
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
